// File: rtl/pic24_icsp_target.sv
// pic24_icsp_target: PIC24 ICSP target-side serial engine.
// Synchronizes the programmer's PGC/PGD/MCLR pins into clk, then decodes
// 4-bit commands.
//   0000 -> SIX: receives a 24-bit instruction into instr and pulses instr_valid.
//   0001 -> REGOUT: 8 pad clocks, then 16 data bits of visi_in driven back on PGD.
//   other -> 24 clocks are discarded and cmd_err is pulsed.
// All serial fields are LSB first.
// Optional feature: define PIC24_TGT_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES clk cycles without a PGC edge.
//
// state | meaning
// IDLE  | MCLRn held low, ICSP logic parked
// CMD   | shifting in the 4-bit command
// SIX   | shifting in the 24-bit instruction payload
// PAD   | 8 turnaround clocks before REGOUT data
// OUT   | driving 16 VISI bits on PGD
// SKIP  | discarding 24 clocks after an unknown command
module pic24_icsp_target #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        MCLRn,
    input  logic        PGCx,
    input  logic        PGDx_in,
    output logic        PGDx_out,
    output logic        PGDx_oe,
    output logic [23:0] instr,
    output logic        instr_valid,
    input  logic [15:0] visi_in,
    output logic        visi_rd,
    output logic        cmd_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_SIX  = 3'd2,
        ST_PAD  = 3'd3,
        ST_OUT  = 3'd4,
        ST_SKIP = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_pgc_sync;
    logic [SYNC_STAGES-1:0] r_pgd_sync;
    logic [SYNC_STAGES-1:0] r_mclr_sync;
    logic                   r_pgc_d;

    logic w_pgc_s;
    logic w_pgd_s;
    logic w_mclr_s;
    logic w_pgc_rise;
    logic w_pgc_fall;
    logic w_idle_tc;

    state_t      r_state;
    logic [4:0]  r_bit_cnt;
    logic [2:0]  r_cmd;
    logic [22:0] r_six;
    logic [15:0] r_visi;

    logic [3:0]  w_cmd_next;
    logic [23:0] w_six_next;

    // Pin synchronizers; reset clears them so MCLRn reads as asserted (low).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pgc_sync  <= '0;
            r_pgd_sync  <= '0;
            r_mclr_sync <= '0;
            r_pgc_d     <= 1'b0;
        end else begin
            r_pgc_sync  <= (r_pgc_sync << 1) | SYNC_STAGES'(PGCx);
            r_pgd_sync  <= (r_pgd_sync << 1) | SYNC_STAGES'(PGDx_in);
            r_mclr_sync <= (r_mclr_sync << 1) | SYNC_STAGES'(MCLRn);
            r_pgc_d     <= r_pgc_sync[SYNC_STAGES-1];
        end
    end

    assign w_pgc_s    = r_pgc_sync[SYNC_STAGES-1];
    assign w_pgd_s    = r_pgd_sync[SYNC_STAGES-1];
    assign w_mclr_s   = r_mclr_sync[SYNC_STAGES-1];
    assign w_pgc_rise = w_pgc_s & ~r_pgc_d;
    assign w_pgc_fall = ~w_pgc_s & r_pgc_d;

    // Next shift values; LSB arrives first so new bits enter at the top.
    assign w_cmd_next = {w_pgd_s, r_cmd};
    assign w_six_next = {w_pgd_s, r_six};

`ifdef PIC24_TGT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TW-1:0] r_idle_cnt;

    // Idle down-counter: reloads in IDLE, on any PGC edge and after firing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if ((r_state == ST_IDLE) || w_pgc_rise || w_pgc_fall || w_idle_tc) begin
            r_idle_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else begin
            r_idle_cnt <= r_idle_cnt - 1'b1;
        end
    end

    assign w_idle_tc = (r_idle_cnt == '0) && (r_state != ST_IDLE) && !w_pgc_rise && !w_pgc_fall;
`else
    // Timeout disabled: the terminal count is constant-false.
    assign w_idle_tc = (TIMEOUT_CYCLES < 0);
`endif

    // Protocol FSM with registered outputs; MCLRn low overrides everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_cmd       <= '0;
            r_six       <= '0;
            r_visi      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            visi_rd     <= 1'b0;
            cmd_err     <= 1'b0;
            PGDx_out    <= 1'b0;
            PGDx_oe     <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            visi_rd     <= 1'b0;
            cmd_err     <= 1'b0;
            if (!w_mclr_s) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                PGDx_oe   <= 1'b0;
                PGDx_out  <= 1'b0;
            end else if (w_idle_tc) begin
                r_state   <= ST_CMD;
                r_bit_cnt <= '0;
                PGDx_oe   <= 1'b0;
                PGDx_out  <= 1'b0;
                cmd_err   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_CMD;
                        r_bit_cnt <= '0;
                    end
                    ST_CMD: begin
                        if (w_pgc_fall) begin
                            r_cmd <= w_cmd_next[3:1];
                            if (r_bit_cnt == 5'd3) begin
                                r_bit_cnt <= '0;
                                case (w_cmd_next)
                                    4'b0000: r_state <= ST_SIX;
                                    4'b0001: r_state <= ST_PAD;
                                    default: begin
                                        r_state <= ST_SKIP;
                                        cmd_err <= 1'b1;
                                    end
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_SIX: begin
                        if (w_pgc_fall) begin
                            r_six <= w_six_next[23:1];
                            if (r_bit_cnt == 5'd23) begin
                                instr       <= w_six_next;
                                instr_valid <= 1'b1;
                                r_state     <= ST_CMD;
                                r_bit_cnt   <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_PAD: begin
                        if (w_pgc_fall) begin
                            if (r_bit_cnt == 5'd7) begin
                                r_visi    <= visi_in;
                                visi_rd   <= 1'b1;
                                r_state   <= ST_OUT;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_OUT: begin
                        if (w_pgc_rise) begin
                            PGDx_oe  <= 1'b1;
                            PGDx_out <= r_visi[0];
                            r_visi   <= {1'b0, r_visi[15:1]};
                        end else if (w_pgc_fall) begin
                            if (r_bit_cnt == 5'd15) begin
                                PGDx_oe   <= 1'b0;
                                PGDx_out  <= 1'b0;
                                r_state   <= ST_CMD;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_SKIP: begin
                        if (w_pgc_fall) begin
                            if (r_bit_cnt == 5'd23) begin
                                r_state   <= ST_CMD;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
